// File: rtl/fx3_pkg.sv
// fx3_pkg: thread-select constants, reader state encoding and default read latency
// shared by the FX3 GPIF II slave-FIFO blocks.
package fx3_pkg;

    localparam logic FX3_THREAD0      = 1'b0;
    localparam logic FX3_THREAD1      = 1'b1;
    localparam int   FX3_READ_LATENCY = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_SETUP,
        ST_READ,
        ST_DRAIN,
        ST_RELEASE
    } rd_state_t;

endpackage

// File: rtl/fx3_capture_pipe.sv
// fx3_capture_pipe: delays each issued read strobe by the FX3 read latency and
// captures the data bus into the sink-FIFO push register when it arrives.
module fx3_capture_pipe #(
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strobe,
    input  logic [DATA_WIDTH-1:0] bus_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  write
);

    logic [READ_LATENCY-1:0] valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            data  <= '0;
            write <= 1'b0;
        end else begin
            valid <= (valid << 1) | READ_LATENCY'(strobe);
            write <= valid[READ_LATENCY-1];
            data  <= valid[READ_LATENCY-1] ? bus_data : data;
        end
    end

endmodule

// File: rtl/fx3_th1_reader.sv
// fx3_th1_reader: FX3 thread-1 slave-FIFO reader; arbitrates for the shared
// address/strobe bus, issues reads and pushes captured words to a sink FIFO.
module fx3_th1_reader
    import fx3_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = FX3_READ_LATENCY,
    parameter int ADDR_SETUP   = 1
) (
    input  logic                  fx3_clock,
    input  logic                  fx3_reset,
    input  logic                  fx3_nReady,
    input  logic                  fx3_th1Ready,
    input  logic                  fx3_th1Watermark,
    input  logic [DATA_WIDTH-1:0] fx3_dataBus,
    output logic                  fx3_nRead,
    output logic                  fx3_nOE,
    output logic                  fx3_addressBus,
    output logic                  bus_request,
    input  logic                  bus_grant,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_write,
    input  logic                  rx_almostFull,
    output logic                  rx_overflow,
    output logic [31:0]           word_count
);

    rd_state_t  state, state_n;
    logic       nready_r, th1_ready_r, watermark_r;
    logic [2:0] cnt, cnt_n;
    logic [3:0] af_cnt;
    logic       nread_n, noe_n, addr_n, req_n;
    logic       read_ok;

    assign read_ok = watermark_r && !nready_r && !rx_almostFull && bus_grant;

    always_ff @(posedge fx3_clock) begin
        if (fx3_reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            nready_r       <= 1'b1;
            th1_ready_r    <= 1'b0;
            watermark_r    <= 1'b0;
            fx3_nRead      <= 1'b1;
            fx3_nOE        <= 1'b1;
            fx3_addressBus <= FX3_THREAD0;
            bus_request    <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            nready_r       <= fx3_nReady;
            th1_ready_r    <= fx3_th1Ready;
            watermark_r    <= fx3_th1Watermark;
            fx3_nRead      <= nread_n;
            fx3_nOE        <= noe_n;
            fx3_addressBus <= addr_n;
            bus_request    <= req_n;
        end
    end

    // Strobe is dropped on the same edge any read condition fails; the drain
    // window then covers every word still in the FX3 read pipeline.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        nread_n = 1'b1;
        noe_n   = fx3_nOE;
        addr_n  = fx3_addressBus;
        req_n   = bus_request;
        case (state)
            ST_IDLE: begin
                if (th1_ready_r && !nready_r && !rx_almostFull) begin
                    state_n = ST_REQUEST;
                    req_n   = 1'b1;
                end
            end
            ST_REQUEST: begin
                if (bus_grant) begin
                    state_n = ST_SETUP;
                    addr_n  = FX3_THREAD1;
                    noe_n   = 1'b0;
                    cnt_n   = '0;
                end else if (!th1_ready_r || nready_r) begin
                    state_n = ST_RELEASE;
                end
            end
            ST_SETUP: begin
                if (cnt == 3'(ADDR_SETUP)) begin
                    state_n = watermark_r ? ST_READ : ST_DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            ST_READ: begin
                if (read_ok) begin
                    nread_n = 1'b0;
                end else begin
                    state_n = ST_DRAIN;
                    cnt_n   = '0;
                end
            end
            ST_DRAIN: begin
                state_n = cnt == 3'(READ_LATENCY) ? ST_RELEASE : ST_DRAIN;
                cnt_n   = cnt + 3'd1;
            end
            ST_RELEASE: begin
                state_n = ST_IDLE;
                noe_n   = 1'b1;
                addr_n  = FX3_THREAD0;
                req_n   = 1'b0;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    fx3_capture_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_capture (
        .clk     (fx3_clock),
        .rst     (fx3_reset),
        .strobe  (!fx3_nRead),
        .bus_data(fx3_dataBus),
        .data    (rx_data),
        .write   (rx_write)
    );

    // A push after almostFull has been high longer than the read pipeline can
    // account for means the sink headroom was breached.
    always_ff @(posedge fx3_clock) begin
        if (fx3_reset) begin
            af_cnt      <= '0;
            rx_overflow <= 1'b0;
            word_count  <= '0;
        end else begin
            af_cnt      <= !rx_almostFull ? '0 : (&af_cnt ? af_cnt : af_cnt + 4'd1);
            rx_overflow <= rx_overflow | (rx_write && af_cnt > 4'(READ_LATENCY + 2));
            word_count  <= word_count + 32'(rx_write);
        end
    end

endmodule

// File: tb/tb_fx3_th1_reader.sv
// tb_fx3_th1_reader: directed bench for the FX3 thread-1 reader with an FX3
// bus model that returns 0x0100 + strobe index after the read latency.
module tb_fx3_th1_reader;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nready = 1'b1, th1_ready = 1'b0, watermark = 1'b0, grant = 1'b0, almost_full = 1'b0;
    logic [15:0] data_bus = '0;
    logic        nread, noe, addr, request, rx_write, overflow;
    logic [15:0] rx_data;
    logic [31:0] word_count;

    int          errors = 0, checks = 0;
    int          st_cnt = 0, rx_cnt = 0;
    logic [15:0] rx_log [0:127];
    logic [15:0] seq = '0;
    logic [4:0]  hist = '0;
    bit          arb_en = 1'b1;
    int          arb_delay = 2, arb_wait = 0;

    fx3_th1_reader #(
        .DATA_WIDTH  (16),
        .READ_LATENCY(L),
        .ADDR_SETUP  (1)
    ) dut (
        .fx3_clock       (clk),
        .fx3_reset       (rst),
        .fx3_nReady      (nready),
        .fx3_th1Ready    (th1_ready),
        .fx3_th1Watermark(watermark),
        .fx3_dataBus     (data_bus),
        .fx3_nRead       (nread),
        .fx3_nOE         (noe),
        .fx3_addressBus  (addr),
        .bus_request     (request),
        .bus_grant       (grant),
        .rx_data         (rx_data),
        .rx_write        (rx_write),
        .rx_almostFull   (almost_full),
        .rx_overflow     (overflow),
        .word_count      (word_count)
    );

    always #5 clk = ~clk;

    // FX3 bus model, sink monitor and arbiter, all mid-cycle.
    always @(negedge clk) begin
        hist = {hist[3:0], !nread};
        if (hist[L]) begin
            data_bus = 16'h0100 + seq;
            seq++;
        end
        if (!nread) st_cnt++;
        if (rx_write) begin
            if (rx_cnt < 128) rx_log[rx_cnt] = rx_data;
            rx_cnt++;
        end
        if (!request) begin
            grant = 1'b0;
            arb_wait = 0;
        end else if (arb_en) begin
            if (arb_wait >= arb_delay) grant = 1'b1;
            else arb_wait++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_flags();
        th1_ready = 1'b1;
        nready    = 1'b0;
        watermark = 1'b1;
    endtask

    task automatic wait_strobes(input int n);
        int t = 0;
        while (st_cnt < n && t < 200) begin
            tick();
            t++;
        end
        checks++;
        if (st_cnt < n) begin errors++; $display("FAIL strobe_wait: strobes=%0d required=%0d", st_cnt, n); end
    endtask

    task automatic wait_release();
        int t = 0;
        while ((request || addr || !noe) && t < 200) begin
            tick();
            t++;
        end
        checks++;
        if (request || addr || !noe) begin errors++; $display("FAIL release_wait: req=%b addr=%b noe=%b required 0 0 1", request, addr, noe); end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (nread !== 1'b1) begin errors++; $display("FAIL reset_nread: got %b want 1", nread); end
        checks++; if (noe !== 1'b1) begin errors++; $display("FAIL reset_noe: got %b want 1", noe); end
        checks++; if (addr !== 1'b0) begin errors++; $display("FAIL reset_addr: got %b want 0", addr); end
        checks++; if (request !== 1'b0) begin errors++; $display("FAIL reset_request: got %b want 0", request); end
        checks++; if (rx_write !== 1'b0) begin errors++; $display("FAIL reset_rx_write: got %b want 0", rx_write); end
        checks++; if (rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx_data: got %h want 0000", rx_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (word_count !== 32'h0) begin errors++; $display("FAIL reset_word_count: got %h want 0", word_count); end
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (request !== 1'b0) begin errors++; $display("FAIL idle_no_request: got %b want 0", request); end
    endtask

    task automatic test_burst();
        int s0 = st_cnt, r0 = rx_cnt;
        arb_en = 1'b1;
        arb_delay = 2;
        start_flags();
        wait_strobes(s0 + 6);
        th1_ready = 1'b0;
        watermark = 1'b0;
        wait_release();
        checks++; if (st_cnt - s0 != 8) begin errors++; $display("FAIL burst_strobes: got %0d want 8", st_cnt - s0); end
        checks++; if (rx_cnt - r0 != 8) begin errors++; $display("FAIL burst_writes: got %0d want 8", rx_cnt - r0); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_log[r0 + i] !== 16'(32'h0100 + i)) begin
                errors++;
                $display("FAIL burst_data[%0d]: got %h want %h", i, rx_log[r0 + i], 16'(32'h0100 + i));
            end
        end
        checks++; if (word_count !== 32'd8) begin errors++; $display("FAIL burst_word_count: got %0d want 8", word_count); end
        checks++; if (addr !== 1'b0) begin errors++; $display("FAIL burst_addr: got %b want 0", addr); end
    endtask

    task automatic test_watermark_fall();
        int s0 = st_cnt, r0 = rx_cnt, t = 0;
        logic [31:0] w0 = word_count;
        start_flags();
        wait_strobes(s0 + 5);
        th1_ready = 1'b0;
        watermark = 1'b0;
        while (!nread && t < 5) begin
            tick();
            t++;
        end
        checks++; if (t > 2) begin errors++; $display("FAIL wm_nread_stop: cycles=%0d want <=2", t); end
        wait_release();
        checks++; if (st_cnt - s0 != 7) begin errors++; $display("FAIL wm_strobes: got %0d want 7", st_cnt - s0); end
        checks++; if (rx_cnt - r0 != 7) begin errors++; $display("FAIL wm_writes: got %0d want 7", rx_cnt - r0); end
        checks++; if (word_count !== w0 + 32'd7) begin errors++; $display("FAIL wm_word_count: got %0d want %0d", word_count, w0 + 32'd7); end
        checks++;
        if (rx_log[r0 + 6] !== 16'(32'h0100 + s0 + 6)) begin
            errors++;
            $display("FAIL wm_last_data: got %h want %h", rx_log[r0 + 6], 16'(32'h0100 + s0 + 6));
        end
    endtask

    task automatic test_almost_full();
        int s0 = st_cnt, r0 = rx_cnt, t = 0;
        start_flags();
        wait_strobes(s0 + 3);
        almost_full = 1'b1;
        wait_release();
        checks++; if (st_cnt - s0 != 4) begin errors++; $display("FAIL af_strobes: got %0d want 4", st_cnt - s0); end
        checks++; if (rx_cnt - r0 != 4) begin errors++; $display("FAIL af_writes: got %0d want 4", rx_cnt - r0); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL af_overflow: got %b want 0", overflow); end
        repeat (5) tick();
        checks++; if (request !== 1'b0) begin errors++; $display("FAIL af_hold_request: got %b want 0", request); end
        almost_full = 1'b0;
        while (!request && t < 20) begin
            tick();
            t++;
        end
        checks++; if (request !== 1'b1) begin errors++; $display("FAIL af_rerequest: got %b want 1", request); end
        wait_strobes(s0 + 7);
        th1_ready = 1'b0;
        watermark = 1'b0;
        wait_release();
        checks++; if (rx_cnt - r0 != st_cnt - s0) begin errors++; $display("FAIL af_resume_writes: got %0d want %0d", rx_cnt - r0, st_cnt - s0); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL af_resume_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid_burst();
        int s0 = st_cnt, r0;
        start_flags();
        wait_strobes(s0 + 2);
        rst = 1'b1;
        th1_ready = 1'b0;
        watermark = 1'b0;
        nready = 1'b1;
        tick();
        checks++; if (nread !== 1'b1) begin errors++; $display("FAIL midrst_nread: got %b want 1", nread); end
        checks++; if (noe !== 1'b1) begin errors++; $display("FAIL midrst_noe: got %b want 1", noe); end
        checks++; if (addr !== 1'b0) begin errors++; $display("FAIL midrst_addr: got %b want 0", addr); end
        checks++; if (request !== 1'b0) begin errors++; $display("FAIL midrst_request: got %b want 0", request); end
        checks++; if (rx_write !== 1'b0) begin errors++; $display("FAIL midrst_rx_write: got %b want 0", rx_write); end
        checks++; if (rx_data !== 16'h0) begin errors++; $display("FAIL midrst_rx_data: got %h want 0000", rx_data); end
        checks++; if (word_count !== 32'h0) begin errors++; $display("FAIL midrst_word_count: got %h want 0", word_count); end
        rst = 1'b0;
        r0 = rx_cnt;
        repeat (8) tick();
        checks++; if (rx_cnt != r0) begin errors++; $display("FAIL midrst_no_write: got %0d writes want 0", rx_cnt - r0); end
        checks++; if (word_count !== 32'h0) begin errors++; $display("FAIL midrst_count_hold: got %h want 0", word_count); end
    endtask

    task automatic test_grant_withheld();
        int s0 = st_cnt, lows = 0, t = 0;
        arb_en = 1'b0;
        start_flags();
        while (!request && t < 10) begin
            tick();
            t++;
        end
        checks++; if (request !== 1'b1) begin errors++; $display("FAIL nogrant_request: got %b want 1", request); end
        repeat (20) begin
            tick();
            if (!nread) lows++;
        end
        th1_ready = 1'b0;
        t = 0;
        while (request && t < 10) begin
            tick();
            t++;
        end
        checks++; if (request !== 1'b0) begin errors++; $display("FAIL nogrant_release: got %b want 0", request); end
        checks++; if (lows != 0) begin errors++; $display("FAIL nogrant_nread: low cycles=%0d want 0", lows); end
        checks++; if (st_cnt != s0) begin errors++; $display("FAIL nogrant_strobes: got %0d want 0", st_cnt - s0); end
        checks++; if (addr !== 1'b0) begin errors++; $display("FAIL nogrant_addr: got %b want 0", addr); end
        watermark = 1'b0;
        nready = 1'b1;
        arb_en = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_wrap();
        int s0, r0;
        force dut.word_count = 32'hFFFF_FFFE;
        tick();
        tick();
        release dut.word_count;
        tick();
        checks++; if (word_count !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_preload: got %h want fffffffe", word_count); end
        s0 = st_cnt;
        r0 = rx_cnt;
        start_flags();
        wait_strobes(s0 + 1);
        th1_ready = 1'b0;
        watermark = 1'b0;
        wait_release();
        checks++; if (rx_cnt - r0 != 3) begin errors++; $display("FAIL wrap_writes: got %0d want 3", rx_cnt - r0); end
        checks++; if (word_count !== 32'h0000_0001) begin errors++; $display("FAIL wrap_count: got %h want 00000001", word_count); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_watermark_fall();
        test_almost_full();
        test_reset_mid_burst();
        test_grant_withheld();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
